// File: rtl/ucsbece154b_stream_pkg.sv
// Shared stream-side types for the FIFO read-side helpers.
package ucsbece154b_stream_pkg;

  typedef enum logic {
    UNPK_IDLE = 1'b0,
    UNPK_SEND = 1'b1
  } unpk_state_e;

endpackage

// File: rtl/ucsbece154b_fifo_unpacker.sv
// Pops wide FIFO entries and replays each as RATIO narrow valid/ready beats,
// low slice first, refilling on the last-beat handshake so entries run gap-free.
//
// state     | meaning
// UNPK_IDLE | nothing held; pop the FIFO head as soon as it is valid
// UNPK_SEND | entry held in buf_q; beat_q selects the slice on data_o
module ucsbece154b_fifo_unpacker
  import ucsbece154b_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [IN_WIDTH-1:0]                    fifo_data_i,
  input  logic                                   fifo_valid_i,
  output logic                                   fifo_pop_o,
  input  logic                                   flush_i,
  output logic [OUT_WIDTH-1:0]                   data_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   last_o,
  output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]  beat_idx_o,
  output logic                                   busy_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = $clog2(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  generate
    if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("ucsbece154b_fifo_unpacker: IN_WIDTH must be a multiple >= 2 of OUT_WIDTH");
    end
  endgenerate

  unpk_state_e          state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [IN_WIDTH-1:0]  buf_q, buf_d;
  logic                 in_send;
  logic                 at_last;
  logic [OUT_WIDTH-1:0] slice;

  assign in_send = (state_q == UNPK_SEND);
  assign at_last = (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNPK_IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and pop; the pop is gated by rst because it is combinational
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    fifo_pop_o = 1'b0;
    if (flush_i) begin
      state_d = UNPK_IDLE;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        UNPK_IDLE: begin
          if (fifo_valid_i && !rst) begin
            fifo_pop_o = 1'b1;
            buf_d      = fifo_data_i;
            beat_d     = '0;
            state_d    = UNPK_SEND;
          end
        end
        UNPK_SEND: begin
          if (ready_i) begin
            if (!at_last) begin
              beat_d = beat_q + 1'b1;
            end else if (fifo_valid_i && !rst) begin
              fifo_pop_o = 1'b1;
              buf_d      = fifo_data_i;
              beat_d     = '0;
            end else begin
              beat_d  = '0;
              state_d = UNPK_IDLE;
            end
          end
        end
        default: begin
          state_d = UNPK_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  // Explicit slice mux keeps non-power-of-two RATIO well defined
  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_q == BW'(i)) slice = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Outputs
  always_comb begin
    valid_o    = in_send;
    busy_o     = in_send;
    data_o     = in_send ? slice : '0;
    last_o     = in_send && at_last;
    beat_idx_o = in_send ? beat_q : '0;
  end

endmodule

// File: tb/tb_ucsbece154b_fifo_unpacker.sv
// Self-checking bench for ucsbece154b_fifo_unpacker (64 -> 32): directed
// scenarios plus a randomized run against a beat-queue reference model.
module tb_ucsbece154b_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fifo_data_i;
  logic        fifo_valid_i;
  logic        fifo_pop_o;
  logic        flush_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic [0:0]  beat_idx_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [0:0]  idx;
  } beat_t;

  ucsbece154b_fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i),
    .fifo_pop_o(fifo_pop_o), .flush_i(flush_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .beat_idx_o(beat_idx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic fv, input logic [63:0] fd,
                       input logic rdy, input logic fl);
    @(negedge clk);
    fifo_valid_i = fv;
    fifo_data_i  = fd;
    ready_i      = rdy;
    flush_i      = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_valid_i = 1'b1; fifo_data_i = 64'h0123_4567_89AB_CDEF;
    ready_i = 1'b1; flush_i = 1'b0;
    #3;
    n_cmp++; if (fifo_pop_o !== 1'b0) begin n_bad++; $display("FAIL reset_pop got=%b want=0", fifo_pop_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", data_o); end
    n_cmp++; if ({last_o, beat_idx_o, busy_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_misc got=%b want=000", {last_o, beat_idx_o, busy_o}); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b want=0", valid_o); end
  endtask

  task automatic test_single();
    logic [63:0] e = 64'hDEADBEEF_CAFEF00D;
    drive(1'b1, e, 1'b1, 1'b0);
    n_cmp++; if (fifo_pop_o !== 1'b1) begin n_bad++; $display("FAIL single_pop got=%b want=1", fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o, last_o} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
      n_bad++; $display("FAIL single_c1 got v=%b d=%h l=%b want v=1 d=cafef00d l=0", valid_o, data_o, last_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o, last_o, beat_idx_o} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL single_c2 got v=%b d=%h l=%b i=%0d want v=1 d=deadbeef l=1 i=1",
                        valid_o, data_o, last_o, beat_idx_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o} !== 33'h0) begin
      n_bad++; $display("FAIL single_c3 got v=%b d=%h want v=0 d=0", valid_o, data_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a = 64'h11111111_00000000;
    logic [63:0] b = 64'h33333333_22222222;
    logic        fv_s  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] fd_s  [6];
    logic        pop_e [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        val_e [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dat_e [6] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0};
    fd_s = '{a, b, b, 64'h0, 64'h0, 64'h0};
    for (int c = 0; c < 6; c++) begin
      drive(fv_s[c], fd_s[c], 1'b1, 1'b0);
      n_cmp++; if ({fifo_pop_o, valid_o, data_o} !== {pop_e[c], val_e[c], dat_e[c]}) begin
        n_bad++; $display("FAIL b2b_c%0d got p=%b v=%b d=%h want p=%b v=%b d=%h",
                          c, fifo_pop_o, valid_o, data_o, pop_e[c], val_e[c], dat_e[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e = 64'hDEADBEEF_CAFEF00D;
    drive(1'b1, e, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
      n_cmp++; if ({valid_o, data_o, beat_idx_o, fifo_pop_o} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL bp_stall%0d got v=%b d=%h i=%0d p=%b want v=1 d=cafef00d i=0 p=0",
                          c, valid_o, data_o, beat_idx_o, fifo_pop_o); end
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (data_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL bp_accept got=%h want=cafef00d", data_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({data_o, beat_idx_o, last_o} !== {32'hDEADBEEF, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL bp_resume got d=%h i=%0d l=%b want d=deadbeef i=1 l=1", data_o, beat_idx_o, last_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_end got=%b want=0", valid_o); end
  endtask

  task automatic test_flush();
    logic [63:0] e1 = 64'hAAAA0001_AAAA0000;
    logic [63:0] e2 = 64'hBBBB0001_BBBB0000;
    drive(1'b1, e1, 1'b1, 1'b0);
    drive(1'b1, e2, 1'b1, 1'b0);
    n_cmp++; if ({data_o, fifo_pop_o} !== {32'hAAAA0000, 1'b0}) begin
      n_bad++; $display("FAIL flush_b0 got d=%h p=%b want d=aaaa0000 p=0", data_o, fifo_pop_o); end
    drive(1'b1, e2, 1'b1, 1'b1);
    n_cmp++; if ({last_o, fifo_pop_o} !== 2'b10) begin
      n_bad++; $display("FAIL flush_cycle got l=%b p=%b want l=1 p=0", last_o, fifo_pop_o); end
    drive(1'b1, e2, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, fifo_pop_o} !== 2'b01) begin
      n_bad++; $display("FAIL flush_after got v=%b p=%b want v=0 p=1", valid_o, fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o} !== {1'b1, 32'hBBBB0000}) begin
      n_bad++; $display("FAIL flush_reload got v=%b d=%h want v=1 d=bbbb0000", valid_o, data_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_idle_gap();
    logic [63:0] e = 64'h0000C0DE_0000BEEF;
    drive(1'b1, e, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({last_o, fifo_pop_o} !== 2'b10) begin
      n_bad++; $display("FAIL gap_last got l=%b p=%b want l=1 p=0", last_o, fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL gap_idle got=%b want=0", valid_o); end
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, fifo_pop_o} !== 2'b01) begin
      n_bad++; $display("FAIL gap_pop got v=%b p=%b want v=0 p=1", valid_o, fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o} !== {1'b1, 32'h9ABCDEF0}) begin
      n_bad++; $display("FAIL gap_valid got v=%b d=%h want v=1 d=9abcdef0", valid_o, data_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL arst_pre got=%b want=1", valid_o); end
    #2;
    rst = 1'b1;
    fifo_valid_i = 1'b1;
    #1;
    n_cmp++; if ({valid_o, last_o, data_o, fifo_pop_o} !== 35'h0) begin
      n_bad++; $display("FAIL arst_now got v=%b l=%b d=%h p=%b want all 0", valid_o, last_o, data_o, fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      n_cmp++; if ({valid_o, fifo_pop_o} !== 2'b00) begin
        n_bad++; $display("FAIL arst_idle%0d got v=%b p=%b want v=0 p=0", c, valid_o, fifo_pop_o); end
    end
    drive(1'b1, 64'h7777_7777_6666_6666, 1'b1, 1'b0);
    n_cmp++; if (fifo_pop_o !== 1'b1) begin n_bad++; $display("FAIL arst_pop got=%b want=1", fifo_pop_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if ({valid_o, data_o} !== {1'b1, 32'h66666666}) begin
      n_bad++; $display("FAIL arst_reload got v=%b d=%h want v=1 d=66666666", valid_o, data_o); end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  // Model: the beats still owed downstream are a queue; pops append both halves.
  task automatic test_random();
    logic [63:0] fifo_q [$];
    beat_t       exp_q  [$];
    beat_t       b;
    logic        fv, rdy, fl, exp_pop, exp_valid;
    logic [63:0] fd;
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1)
        fifo_q.push_back({$urandom, $urandom});
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      fv  = (fifo_q.size() != 0) && ($urandom_range(0, 4) != 0);
      fd  = fv ? fifo_q[0] : {$urandom, $urandom};
      drive(fv, fd, rdy, fl);
      exp_valid = (exp_q.size() != 0);
      n_cmp++; if (valid_o !== exp_valid) begin
        n_bad++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, valid_o, exp_valid); end
      if (!valid_o) begin
        n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL rand_data0 c=%0d got=%h want=0", c, data_o); end
      end
      if (valid_o && rdy && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        n_cmp++; if ({data_o, last_o, beat_idx_o} !== {b.data, b.last, b.idx}) begin
          n_bad++; $display("FAIL rand_beat c=%0d got d=%h l=%b i=%0d want d=%h l=%b i=%0d",
                            c, data_o, last_o, beat_idx_o, b.data, b.last, b.idx); end
      end
      if (fl) exp_q.delete();
      exp_pop = fv && !fl && (exp_q.size() == 0);
      n_cmp++; if (fifo_pop_o !== exp_pop) begin
        n_bad++; $display("FAIL rand_pop c=%0d got=%b want=%b", c, fifo_pop_o, exp_pop); end
      if (exp_pop) begin
        for (int k = 0; k < 2; k++) begin
          b.data = fd[k*32 +: 32];
          b.last = (k == 1);
          b.idx  = 1'(k);
          exp_q.push_back(b);
        end
        void'(fifo_q.pop_front());
      end
    end
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rand_drain got=%b want=0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_idle_gap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fifo_unpacker.md
Name: ucsbece154b_fifo_unpacker

Overview:
Read-side companion to the team's pop-interface FIFO (data/valid/pop). It pops one wide FIFO entry at a time and emits that entry as RATIO narrow beats on a valid/ready stream, low slice first. Typical use: a 64-bit fetch FIFO drained into 32-bit instruction beats toward decode. It pops the next entry on the same cycle the last beat of the current entry is accepted, so there is no bubble between entries.

Parameters:
IN_WIDTH, 64, FIFO entry width; must be an exact multiple of OUT_WIDTH.
OUT_WIDTH, 32, output beat width.
RATIO (localparam), IN_WIDTH/OUT_WIDTH, beats per entry; must be >= 2 (elaboration assertion).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
fifo_data_i  input  IN_WIDTH  FIFO head entry (combinational from FIFO)
fifo_valid_i  input  1  FIFO non-empty
fifo_pop_o  output  1  pop the FIFO head this cycle
flush_i  input  1  discard the held entry and return to idle
data_o  output  OUT_WIDTH  current beat
valid_o  output  1  beat valid
ready_i  input  1  downstream accepts beat
last_o  output  1  current beat is the final slice of its entry
beat_idx_o  output  $clog2(RATIO)  index of the current beat
busy_o  output  1  an entry is held (equals valid_o)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high, and clears all state immediately.
- Reset values: state IDLE, beat_q 0, buf_q 0. Outputs: valid_o 0, data_o 0, last_o 0, beat_idx_o 0, busy_o 0, fifo_pop_o 0.
- State machine:
  - IDLE: valid_o 0. If fifo_valid_i and !flush_i: assert fifo_pop_o, capture fifo_data_i into buf_q, set beat_q to 0, go to SEND.
  - SEND: valid_o 1.
    - data_o = buf_q[beat_q*OUT_WIDTH +: OUT_WIDTH].
    - last_o = (beat_q == RATIO-1).
    - beat_idx_o = beat_q.
- Beat transfer: occurs when valid_o && ready_i.
  - Non-last beat: beat_q increments.
  - Last beat with fifo_valid_i: assert fifo_pop_o the same cycle, load the new entry, set beat_q to 0, stay in SEND.
  - Last beat without fifo_valid_i: go to IDLE, beat_q to 0.
- Backpressure: while valid_o && !ready_i, data_o, last_o and beat_idx_o are held stable and fifo_pop_o is 0.
- fifo_pop_o is combinational. It is never asserted when fifo_valid_i is 0, when flush_i is 1, or during reset.
- Latency: one cycle from fifo_valid_i (in IDLE) to valid_o.
- Throughput: one beat per cycle with ready_i held high. Consecutive entries produce no idle cycle.
- flush_i has priority over everything.
  - Next cycle: IDLE, beat_q 0, valid_o 0.
  - No pop in the flush cycle, even on a last-beat handshake. Any beat transfer in that same cycle still counts as delivered downstream.
  - Reload from the FIFO starts the cycle after the flush.
- data_o is 0 whenever valid_o is 0.
- Reset mid-SEND: the held entry is lost (already popped); the block is IDLE on release.
- beat_q width is $clog2(RATIO). Wrap from RATIO-1 to 0 is explicit, so non-power-of-two RATIO works.

Decomposition:
- Shared package ucsbece154b_stream_pkg: typedef enum logic {UNPK_IDLE, UNPK_SEND} unpk_state_e.
- No sub-module. One always_comb for next-state and pop logic, one always_ff with asynchronous reset for state, beat_q and buf_q.

Test Plan (IN_WIDTH 64, OUT_WIDTH 32):
1. Single entry 0xDEADBEEF_CAFEF00D, ready_i=1.
   - c0: fifo_pop_o=1.
   - c1: data_o=0xCAFEF00D, last_o=0.
   - c2: data_o=0xDEADBEEF, last_o=1, beat_idx_o=1.
   - c3: valid_o=0.
2. Two back-to-back entries A=0x11111111_00000000, B=0x33333333_22222222, ready_i=1.
   - Beats 0x0, 0x11111111, 0x22222222, 0x33333333 on four consecutive cycles.
   - fifo_pop_o high at c0 and c2 only.
3. Backpressure: ready_i=0 for 3 cycles during beat 0.
   - data_o stays 0xCAFEF00D, fifo_pop_o=0.
   - Raising ready_i resumes with beat 1 the next cycle.
4. Flush at beat 1 with fifo_valid_i=1.
   - fifo_pop_o=0 that cycle.
   - Next cycle valid_o=0.
   - The following cycle pops and loads the next entry.
5. Asynchronous reset mid-SEND, asserted between clock edges.
   - valid_o, last_o and data_o go 0 without waiting for an edge.
   - After release the block stays IDLE until fifo_valid_i=1.
6. Last-beat handshake with fifo_valid_i=0, then fifo_valid_i rises 2 cycles later.
   - One IDLE period.
   - Pop when fifo_valid_i rises, valid_o one cycle after.
